// File: rtl/pipeline_rb_subtractor.sv
// Three-stage pipelined ripple-borrow subtractor (diff = a - b - bin) with a valid/ready stall.
// Define PIPE_SUB_OVF_EN to add the registered signed-overflow output ovf.
module pipeline_rb_subtractor #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SEG1  = 23,
  parameter int unsigned SEG2  = 46
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef PIPE_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned UW1 = WIDTH - SEG1;
  localparam int unsigned UW2 = WIDTH - SEG2;
  localparam int unsigned MW  = SEG2 - SEG1;

  logic adv;

  logic [SEG1-1:0]  d1_d, d1_q;
  logic             br1_d, br1_q;
  logic [UW1-1:0]   a1_d, a1_q, b1_d, b1_q;
  logic             v1_d, v1_q;

  logic [SEG2-1:0]  d2_d, d2_q;
  logic             br2_d, br2_q;
  logic [UW2-1:0]   a2_d, a2_q, b2_d, b2_q;
  logic             v2_d, v2_q;

  logic [WIDTH-1:0] diff_d, diff_q;
  logic             bout_d, bout_q;
  logic             out_valid_d, out_valid_q;

  // A full output slot that is not being drained freezes the whole pipe.
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  always_comb begin : s1_comb
    logic br;
    br   = bin;
    d1_d = '0;
    for (int unsigned i = 0; i < SEG1; i++) begin
      d1_d[i] = a[i] ^ b[i] ^ br;
      br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    br1_d = br;
    a1_d  = a[WIDTH-1:SEG1];
    b1_d  = b[WIDTH-1:SEG1];
    v1_d  = in_valid;
  end

  always_comb begin : s2_comb
    logic          br;
    logic [MW-1:0] dm;
    br = br1_q;
    dm = '0;
    for (int unsigned i = 0; i < MW; i++) begin
      dm[i] = a1_q[i] ^ b1_q[i] ^ br;
      br    = (~a1_q[i] & b1_q[i]) | (~(a1_q[i] ^ b1_q[i]) & br);
    end
    d2_d  = {dm, d1_q};
    br2_d = br;
    a2_d  = a1_q[UW1-1:MW];
    b2_d  = b1_q[UW1-1:MW];
    v2_d  = v1_q;
  end

  always_comb begin : s3_comb
    logic           br;
    logic [UW2-1:0] dh;
    br = br2_q;
    dh = '0;
    for (int unsigned i = 0; i < UW2; i++) begin
      dh[i] = a2_q[i] ^ b2_q[i] ^ br;
      br    = (~a2_q[i] & b2_q[i]) | (~(a2_q[i] ^ b2_q[i]) & br);
    end
    diff_d      = {dh, d2_q};
    bout_d      = br;
    out_valid_d = v2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_q        <= '0;
      br1_q       <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      v1_q        <= 1'b0;
      d2_q        <= '0;
      br2_q       <= 1'b0;
      a2_q        <= '0;
      b2_q        <= '0;
      v2_q        <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      d1_q        <= d1_d;
      br1_q       <= br1_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      v1_q        <= v1_d;
      d2_q        <= d2_d;
      br2_q       <= br2_d;
      a2_q        <= a2_d;
      b2_q        <= b2_d;
      v2_q        <= v2_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef PIPE_SUB_OVF_EN
  logic ovf_d, ovf_q;

  // Operand sign bits ride along as the top bits of the upper-segment operand registers.
  always_comb begin
    ovf_d = (a2_q[UW2-1] ^ b2_q[UW2-1]) & (diff_d[WIDTH-1] ^ a2_q[UW2-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign diff      = diff_q;
  assign bout      = bout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipeline_rb_subtractor.sv
// Self-checking bench for pipeline_rb_subtractor: directed steps feed a scoreboard queue that
// an output monitor drains, plus latency, stall, and reset checks.
module tb_pipeline_rb_subtractor;
  localparam int W = 64;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         bout;
`ifdef PIPE_SUB_OVF_EN
  logic         ovf;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  pipeline_rb_subtractor dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef PIPE_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mbin);
    exp_t       e;
    logic [W:0] r;
    r      = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    e.diff = r[W-1:0];
    e.bout = r[W];
    e.ovf  = (ma[W-1] ^ mb[W-1]) & (r[W-1] ^ ma[W-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Output side of the scoreboard: compare on each completed transfer.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {{(W-1){1'b0}}, out_valid}, '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", diff, e.diff);
        chk("bout", {{(W-1){1'b0}}, bout}, {{(W-1){1'b0}}, e.bout});
`ifdef PIPE_SUB_OVF_EN
        chk("ovf", {{(W-1){1'b0}}, ovf}, {{(W-1){1'b0}}, e.ovf});
`endif
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    logic acc;
    bit   done;
    done     = 0;
    a        = ta;
    b        = tb_v;
    bin      = tbin;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        sb.push_back(model(ta, tb_v, tbin));
        done = 1;
      end
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL accept_timeout: observed=not_accepted expected=accepted");
    end
    #1 in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge (edge 1) to the one that raises out_valid.
  task automatic lat_check(input string tag);
    int lat;
    lat = 1;
    chk({tag, "_early"}, {{(W-1){1'b0}}, out_valid}, '0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid === 1'b1) break;
    end
    chk(tag, W'(lat), W'(3));
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
    #1 chk("drain_empty", W'(sb.size()), '0);
  endtask

  initial begin
    exp_t e;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    chk("rst_diff", diff, '0);
    chk("rst_bout", {{(W-1){1'b0}}, bout}, '0);
    chk("rst_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic op and latency.
    send(64'd5, 64'd3, 1'b0);
    lat_check("latency_basic");
    drain();

    // Borrow across both segment boundaries; borrow resolved at SEG1 and SEG2.
    send(64'd0, 64'd1, 1'b0);
    send(64'h80_0000, 64'd0, 1'b1);
    send(64'h4000_0000_0000, 64'd0, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    drain();

    // Four back-to-back ops with a two-cycle downstream stall mid-stream.
    fork
      begin
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        send(64'h0000_0000_007F_FFFF, 64'h0000_0000_0080_0000, 1'b1);
        send(64'hDEAD_BEEF_0000_0000, 64'h0000_0001_0000_0001, 1'b1);
        send(64'h0000_4000_0000_0000, 64'h0000_3FFF_FFFF_FFFF, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        chk("stall_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});
        e = sb[0];
        for (int k = 0; k < 2; k++) begin
          @(posedge clk);
          #1;
          chk("stall_in_ready", {{(W-1){1'b0}}, in_ready}, '0);
          chk("stall_hold_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});
          chk("stall_hold_diff", diff, e.diff);
          chk("stall_hold_bout", {{(W-1){1'b0}}, bout}, {{(W-1){1'b0}}, e.bout});
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight.
    send(64'd100, 64'd1, 1'b0);
    send(64'd200, 64'd2, 1'b0);
    send(64'd300, 64'd3, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    chk("midrst_diff", diff, '0);
    chk("midrst_bout", {{(W-1){1'b0}}, bout}, '0);
    chk("midrst_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    send(64'd9, 64'd4, 1'b1);
    lat_check("latency_after_rst");
    drain();

    // Random back-to-back stream.
    for (int k = 0; k < 8; k++) begin
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
